// File: rtl/alu_seq_acc.sv
// Sequential ALU with a registered result, an internal accumulator and an
// iterative shift-add multiplier behind a valid/ready request handshake.
module alu_seq_acc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             use_acc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    // state  | meaning
    // S_IDLE | ready for a request; non-MUL ops complete one cycle after accept
    // S_MUL  | shift-add iterations running, then one drain cycle (cnt_q == 0)

    localparam int SH = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t               state_q, state_d;
    logic                 rdy_q;
    logic [SH-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [WIDTH-1:0]     acc_q;

    logic                 accept;
    logic [WIDTH-1:0]     opa;
    logic [SH-1:0]        sh_n;
    logic [2*WIDTH-1:0]   mul_first;
    logic [2*WIDTH-1:0]   mul_next;

    logic                 ld_alu, ld_mul, start_mul, step_mul;

    logic [WIDTH:0]       sum_w, dif_w, shl_w, shr_w;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c, alu_v;

    logic [WIDTH-1:0]     res_d;
    logic                 c_d, v_d;

    // One shift-add step: conditionally add the multiplicand into the high
    // half, then shift the whole product right, keeping the add's carry.
    function automatic logic [2*WIDTH-1:0] mul_step(
        input logic [2*WIDTH-1:0] p,
        input logic [WIDTH-1:0]   m
    );
        logic [WIDTH:0] s;
        s = {1'b0, p[2*WIDTH-1:WIDTH]};
        if (p[0]) begin
            s = s + {1'b0, m};
        end
        return {s, p[WIDTH-1:1]};
    endfunction

    assign in_ready  = rdy_q;
    assign accept    = in_valid && rdy_q;
    assign opa       = use_acc ? acc_q : a;
    assign sh_n      = b[SH-1:0];

    // The first iteration runs on the accept edge so the last one lands
    // WIDTH-1 edges later, giving out_valid WIDTH cycles after accept.
    assign mul_first = mul_step({{WIDTH{1'b0}}, b}, opa);
    assign mul_next  = mul_step(prod_q, mcand_q);

    always_comb begin
        sum_w   = {1'b0, opa} + {1'b0, b};
        dif_w   = {1'b0, opa} - {1'b0, b};
        shl_w   = {1'b0, opa} << sh_n;
        shr_w   = {opa, 1'b0} >> sh_n;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum_w[WIDTH-1:0];
                alu_c   = sum_w[WIDTH];
                alu_v   = (opa[WIDTH-1] == b[WIDTH-1]) &&
                          (sum_w[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = dif_w[WIDTH-1:0];
                alu_c   = dif_w[WIDTH];
                alu_v   = (opa[WIDTH-1] != b[WIDTH-1]) &&
                          (dif_w[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_AND: alu_res = opa & b;
            OP_OR:  alu_res = opa | b;
            OP_XOR: alu_res = opa ^ b;
            OP_SHL: begin
                alu_res = shl_w[WIDTH-1:0];
                alu_c   = shl_w[WIDTH];
            end
            OP_SHR: begin
                alu_res = shr_w[WIDTH:1];
                alu_c   = shr_w[0];
            end
            default: begin
                alu_res = '0;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ld_alu    = 1'b0;
        ld_mul    = 1'b0;
        start_mul = 1'b0;
        step_mul  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        state_d   = S_MUL;
                        start_mul = 1'b1;
                    end else begin
                        ld_alu = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    step_mul = 1'b1;
                    ld_mul   = (cnt_q == SH'(1));
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        res_d = alu_res;
        c_d   = alu_c;
        v_d   = alu_v;
        if (ld_mul) begin
            res_d = mul_next[WIDTH-1:0];
            c_d   = |mul_next[2*WIDTH-1:WIDTH];
            v_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rdy_q     <= 1'b0;
            cnt_q     <= '0;
            prod_q    <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            state_q   <= state_d;
            rdy_q     <= (state_d == S_IDLE);
            out_valid <= ld_alu || ld_mul;
            if (ld_alu || ld_mul) begin
                result <= res_d;
                acc_q  <= res_d;
                carry  <= c_d;
                zero   <= (res_d == '0);
                neg    <= res_d[WIDTH-1];
                ovf    <= v_d;
            end
            if (start_mul) begin
                prod_q  <= mul_first;
                mcand_q <= opa;
                cnt_q   <= SH'(WIDTH - 1);
            end else if (step_mul) begin
                prod_q <= mul_next;
                cnt_q  <= cnt_q - SH'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_acc.sv
// Directed bench for alu_seq_acc: stimulus pushes hand-computed expectations,
// a monitor pops and checks them on every out_valid.
module tb_alu_seq_acc;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] XOR = 3'b100;
    localparam logic [2:0] SHL = 3'b101;
    localparam logic [2:0] SHR = 3'b110;
    localparam logic [2:0] MUL = 3'b111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] op = 3'b000;
    logic       use_acc = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       out_valid;
    logic [7:0] result;
    logic       carry, zero, neg, ovf;

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic [11:0] flds;   // {result, carry, zero, neg, ovf}
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];

    alu_seq_acc #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .use_acc(use_acc), .a(a), .b(b), .out_valid(out_valid),
        .result(result), .carry(carry), .zero(zero), .neg(neg), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got result=%0h, expected no completion (cycle %0d)",
                         result, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_flags"}, {20'h0, result, carry, zero, neg, ovf}, {20'h0, e.flds});
                check({e.name, "_cycle"}, cyc, e.cyc);
            end
        end
    end

    // Called at a negedge; holds the request until accepted, returns at the
    // negedge after the accept edge with in_valid still high.
    task automatic send(input string name, input logic [2:0] o, input logic u,
                        input logic [7:0] aa, input logic [7:0] bb,
                        input logic [7:0] er, input logic ec, input logic ez,
                        input logic en, input logic eo, input bit expect_out,
                        output int waited);
        exp_t e;
        op = o; use_acc = u; a = aa; b = bb; in_valid = 1'b1;
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_accept_timeout: got in_ready=0 for %0d cycles, expected acceptance", name, waited);
        end else if (expect_out) begin
            e.flds = {er, ec, ez, en, eo};
            e.cyc  = cyc + ((o == MUL) ? 8 : 1);
            e.name = name;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic check_cleared(input string name);
        check({name, "_result"}, {24'h0, result}, 32'h0);
        check({name, "_flags"}, {28'h0, carry, zero, neg, ovf}, 32'h0);
        check({name, "_out_valid"}, {31'h0, out_valid}, 32'h0);
    endtask

    initial begin
        int w;
        // reset held three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_cleared("reset");
            check("reset_in_ready", {31'h0, in_ready}, 32'h0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {31'h0, in_ready}, 32'h1);

        // ADD/SUB flags, back-to-back
        send("add_200_100", ADD, 1'b0, 8'd200, 8'd100, 8'd44, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, w);
        send("sub_5_7",     SUB, 1'b0, 8'd5,   8'd7,   8'd254, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, w);
        send("sub_80_01",   SUB, 1'b0, 8'h80,  8'h01,  8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, w);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);

        // MUL with the following request held high throughout
        send("mul_13_11", MUL, 1'b0, 8'd13, 8'd11, 8'h8F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, w);
        send("add_after_mul", ADD, 1'b0, 8'd1, 8'd1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, w);
        check("mul1_ready_low_cycles", w, 8);
        send("mul_20_20", MUL, 1'b0, 8'd20, 8'd20, 8'h90, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, w);
        send("add_after_mul2", ADD, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, w);
        check("mul2_ready_low_cycles", w, 8);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);

        // accumulator chain at one request per cycle
        send("chain_add",     ADD, 1'b0, 8'd3,  8'd4,  8'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, w);
        send("chain_acc_add", ADD, 1'b1, 8'hFF, 8'd10, 8'd17, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, w);
        send("chain_acc_xor", XOR, 1'b1, 8'hFF, 8'd17, 8'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, w);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);

        // shifts
        send("shl_81_1", SHL, 1'b0, 8'h81, 8'd1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, w);
        send("shr_81_8", SHR, 1'b0, 8'h81, 8'd8, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, w);
        send("shr_81_7", SHR, 1'b0, 8'h81, 8'd7, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, w);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);

        // reset four cycles into a MUL aborts it and clears the accumulator
        send("mul_255_255", MUL, 1'b0, 8'd255, 8'd255, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, w);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_cleared("mid_mul_reset");
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_mid_mul_reset", {31'h0, in_ready}, 32'h1);
        check_cleared("after_mid_mul_reset");
        send("acc_add_5", ADD, 1'b1, 8'hAA, 8'd5, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, w);
        in_valid = 1'b0;

        repeat (12) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
